saturn_fetch: RTL and testbench

Nibble fetch unit feeding the Saturn instruction decoder. It owns the program counter and issues single-nibble reads on the memory bus with a req/ack handshake. Fetched nibbles go into a small prefetch FIFO, and the decoder receives one `{pc, nibble}` pair per cycle, with a stall flag while no nibble is available. PC redirects (jumps, returns, reset vector) flush the FIFO and restart fetching from the new address.

---
 rtl/saturn_fetch.sv | 144 ++++++++++++++
 tb/tb_saturn_fetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/saturn_fetch.sv
// saturn_fetch: nibble fetch unit for the Saturn decoder.
// Owns the fetch address, issues single-nibble bus reads with a req/ack
// handshake, buffers results in a small prefetch FIFO and presents the head
// entry as {o_pc, o_nibble}. Redirects flush the FIFO and restart fetching.
// Optional feature macro: SATURN_FETCH_PREFETCH_EN
//   defined   - up to DEPTH nibbles are fetched ahead of the decoder
//   undefined - a request is issued only while the FIFO is empty (depth 1)
module saturn_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [19:0] RESET_PC = 20'h00000
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_en_fetch,
  input  logic                     i_inc_pc,
  input  logic                     i_load_pc,
  input  logic [19:0]              i_new_pc,
  output logic [19:0]              o_bus_addr,
  output logic                     o_bus_req,
  input  logic                     i_bus_ack,
  input  logic [3:0]               i_bus_data,
  output logic [19:0]              o_pc,
  output logic [3:0]               o_nibble,
  output logic                     o_stalled,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t            state;
  logic [19:0]       fa;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_next;
  logic [19:0]       mem_addr [DEPTH];
  logic [3:0]        mem_nib  [DEPTH];

  logic              push;
  logic              pop;
  logic [LVL_W-1:0]  level_nxt;
  logic              issue_ok;
  logic              room_after;

  // Handshake qualifiers, post-update occupancy and request admission.
  always_comb begin
    pop       = i_inc_pc && i_en_fetch && !o_stalled && !i_load_pc;
    push      = i_reset && (state == REQ) && i_bus_ack && !i_load_pc;
    level_nxt = o_level + LVL_W'(push) - LVL_W'(pop);
    rd_next   = rd_ptr + PTR_W'(1);
`ifdef SATURN_FETCH_PREFETCH_EN
    issue_ok   = (o_level < LVL_W'(DEPTH));
    room_after = (level_nxt < LVL_W'(DEPTH));
`else
    issue_ok   = (o_level == '0) && !pop;
    room_after = (level_nxt == '0);
`endif
  end

  // FIFO storage; written only by an accepted ack, never reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= fa;
      mem_nib[wr_ptr]  <= i_bus_data;
    end
  end

  // Bus FSM, fetch address, FIFO pointers and registered decoder outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state      <= IDLE;
      fa         <= RESET_PC;
      o_bus_addr <= RESET_PC;
      o_bus_req  <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      o_level    <= '0;
      o_stalled  <= 1'b1;
      o_pc       <= '0;
      o_nibble   <= '0;
    end else if (i_load_pc) begin
      // Redirect: drop everything in flight, including a same-cycle ack.
      state      <= IDLE;
      fa         <= i_new_pc;
      o_bus_addr <= i_new_pc;
      o_bus_req  <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      o_level    <= '0;
      o_stalled  <= 1'b1;
      o_pc       <= '0;
      o_nibble   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        fa     <= fa + 20'd1;
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      o_level   <= level_nxt;
      o_stalled <= (level_nxt == '0);

      // New head: the pushed entry if the FIFO is (or becomes) otherwise
      // empty, else the entry behind the popped one.
      if (push && ((o_level == '0) || ((o_level == LVL_W'(1)) && pop))) begin
        o_pc     <= fa;
        o_nibble <= i_bus_data;
      end else if (pop && (o_level > LVL_W'(1))) begin
        o_pc     <= mem_addr[rd_next];
        o_nibble <= mem_nib[rd_next];
      end

      case (state)
        IDLE: begin
          o_bus_addr <= fa;
          if (issue_ok) begin
            state     <= REQ;
            o_bus_req <= 1'b1;
          end
        end
        REQ: begin
          if (push) begin
            o_bus_addr <= fa + 20'd1;
            if (!room_after) begin
              state     <= IDLE;
              o_bus_req <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          o_bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_saturn_fetch.sv
// Self-checking bench for saturn_fetch: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_saturn_fetch;

  localparam int unsigned DEPTH = 4;
  localparam logic [19:0] RPC   = 20'h00100;
`ifdef SATURN_FETCH_PREFETCH_EN
  localparam int EFF = DEPTH;
  localparam bit PF  = 1'b1;
`else
  localparam int EFF = 1;
  localparam bit PF  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, en, inc, load, ack;
  logic [19:0] new_pc;
  logic [3:0]  data;
  logic [19:0] bus_addr, pc;
  logic        bus_req, stalled;
  logic [3:0]  nibble;
  logic [2:0]  level;

  always #5 clk = ~clk;

  saturn_fetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_en_fetch (en),
    .i_inc_pc   (inc),
    .i_load_pc  (load),
    .i_new_pc   (new_pc),
    .o_bus_addr (bus_addr),
    .o_bus_req  (bus_req),
    .i_bus_ack  (ack),
    .i_bus_data (data),
    .o_pc       (pc),
    .o_nibble   (nibble),
    .o_stalled  (stalled),
    .o_level    (level)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of fetched {addr, nibble} plus request status.
  typedef struct packed {
    logic [19:0] a;
    logic [3:0]  n;
  } ent_t;

  ent_t        q[$];
  logic [19:0] m_fa;
  logic [19:0] m_addr;
  bit          m_req;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int sz0;
    bit acc, pp;
    sz0 = q.size();
    if (!rst_n) begin
      q.delete(); m_fa = RPC; m_addr = RPC; m_req = 1'b0;
    end else if (load) begin
      q.delete(); m_fa = new_pc; m_addr = new_pc; m_req = 1'b0;
    end else begin
      acc = m_req && ack;
      pp  = inc && en && (sz0 > 0);
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back({m_fa, data});
        m_fa = m_fa + 20'd1;
      end
      if (m_req) begin
        if (acc) begin
          m_addr = m_fa;
          m_req  = (q.size() < EFF);
        end
      end else begin
        m_addr = m_fa;
        m_req  = PF ? (sz0 < EFF) : ((sz0 == 0) && !pp);
      end
    end
  endtask

  task automatic check_model();
    cmp("m_req", 32'(bus_req), 32'(m_req));
    if (m_req) cmp("m_addr", 32'(bus_addr), 32'(m_addr));
    cmp("m_stalled", 32'(stalled), 32'(q.size() == 0));
    cmp("m_level", 32'(level), 32'(q.size()));
    cmp("m_level_max", 32'(int'(level) <= EFF), 32'd1);
    if (q.size() > 0) begin
      cmp("m_pc", 32'(pc), 32'(q[0].a));
      cmp("m_nib", 32'(nibble), 32'(q[0].n));
    end
  endtask

  // One clock: update model from current inputs, clock, sample 1ns later.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; load = 1'b0; new_pc = '0; ack = 1'b0; data = '0; inc = 1'b0; en = 1'b0;
  endtask

  typedef struct {
    bit          rst;
    bit          ld;
    logic [19:0] npc;
    bit          ak;
    logic [3:0]  d;
    bit          pp;
    bit          req_pf;
    bit          req_np;
    bit          chk_addr;
    logic [19:0] addr;
    bit          stl;
    logic [2:0]  lvl;
    bit          chk_head;
    logic [19:0] p;
    logic [3:0]  n;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(int rst, int ld, int npc, int ak, int d, int pp,
                              int rpf, int rnp, int ca, int ad, int st, int lv,
                              int ch, int p, int n);
    vec_t r;
    r.rst = 1'(rst); r.ld = 1'(ld); r.npc = 20'(npc); r.ak = 1'(ak); r.d = 4'(d);
    r.pp = 1'(pp); r.req_pf = 1'(rpf); r.req_np = 1'(rnp); r.chk_addr = 1'(ca);
    r.addr = 20'(ad); r.stl = 1'(st); r.lvl = 3'(lv); r.chk_head = 1'(ch);
    r.p = 20'(p); r.n = 4'(n);
    return r;
  endfunction

  initial begin
    logic [2:0] pre_level;
    idle_inputs();
    rst_n = 1'b0;

    //            rst ld npc       ak d  pop  rpf rnp ca addr      st lv ch pc       nib
    tbl[0]  = mk(0, 0, 0,        0, 0, 0,   0, 0, 1, 'h00100, 1, 0, 1, 0,       0);
    tbl[1]  = mk(1, 0, 0,        0, 0, 0,   1, 1, 1, 'h00100, 1, 0, 0, 0,       0);
    tbl[2]  = mk(1, 0, 0,        0, 0, 1,   1, 1, 1, 'h00100, 1, 0, 0, 0,       0);
    tbl[3]  = mk(1, 0, 0,        1, 'hA, 0, 1, 0, 0, 0,       0, 1, 1, 'h00100, 'hA);
    tbl[4]  = mk(1, 0, 0,        0, 0, 1,   1, 0, 0, 0,       1, 0, 0, 0,       0);
    tbl[5]  = mk(1, 0, 0,        0, 0, 0,   1, 1, 1, 'h00101, 1, 0, 0, 0,       0);
    tbl[6]  = mk(1, 1, 'hFFFFE,  1, 5, 0,   0, 0, 0, 0,       1, 0, 0, 0,       0);
    tbl[7]  = mk(1, 0, 0,        0, 0, 0,   1, 1, 1, 'hFFFFE, 1, 0, 0, 0,       0);
    tbl[8]  = mk(1, 0, 0,        1, 1, 0,   1, 0, 0, 0,       0, 1, 1, 'hFFFFE, 1);
    tbl[9]  = mk(1, 0, 0,        0, 0, 1,   1, 0, 0, 0,       1, 0, 0, 0,       0);
    tbl[10] = mk(1, 0, 0,        0, 0, 0,   1, 1, 1, 'hFFFFF, 1, 0, 0, 0,       0);
    tbl[11] = mk(1, 0, 0,        1, 2, 0,   1, 0, 0, 0,       0, 1, 1, 'hFFFFF, 2);
    tbl[12] = mk(1, 0, 0,        0, 0, 1,   1, 0, 0, 0,       1, 0, 0, 0,       0);
    tbl[13] = mk(1, 0, 0,        0, 0, 0,   1, 1, 1, 'h00000, 1, 0, 0, 0,       0);
    tbl[14] = mk(1, 0, 0,        1, 3, 0,   1, 0, 0, 0,       0, 1, 1, 'h00000, 3);
    tbl[15] = mk(1, 1, 'h2A000,  0, 0, 1,   0, 0, 0, 0,       1, 0, 0, 0,       0);
    tbl[16] = mk(1, 0, 0,        0, 0, 0,   1, 1, 1, 'h2A000, 1, 0, 0, 0,       0);
    tbl[17] = mk(1, 0, 0,        1, 9, 0,   1, 0, 0, 0,       0, 1, 1, 'h2A000, 9);
    tbl[18] = mk(0, 0, 0,        1, 7, 0,   0, 0, 1, 'h00100, 1, 0, 1, 0,       0);
    tbl[19] = mk(1, 0, 0,        0, 0, 0,   1, 1, 1, 'h00100, 1, 0, 0, 0,       0);

    // Directed vector table.
    for (int i = 0; i < 20; i++) begin
      rst_n = tbl[i].rst; load = tbl[i].ld; new_pc = tbl[i].npc;
      ack = tbl[i].ak; data = tbl[i].d; inc = tbl[i].pp; en = tbl[i].pp;
      cyc();
      cmp("tbl_req", 32'(bus_req), 32'(PF ? tbl[i].req_pf : tbl[i].req_np));
      if (tbl[i].chk_addr) cmp("tbl_addr", 32'(bus_addr), 32'(tbl[i].addr));
      cmp("tbl_stalled", 32'(stalled), 32'(tbl[i].stl));
      cmp("tbl_level", 32'(level), 32'(tbl[i].lvl));
      if (tbl[i].chk_head) begin
        cmp("tbl_pc", 32'(pc), 32'(tbl[i].p));
        cmp("tbl_nib", 32'(nibble), 32'(tbl[i].n));
      end
    end

    // Reset and fill: ack every cycle, no pops.
    idle_inputs(); rst_n = 1'b0; cyc();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      ack = 1'b1; data = 4'(i + 3);
      cyc();
    end
    cmp("fill_level", 32'(level), 32'(EFF));
    cmp("fill_req", 32'(bus_req), 32'd0);
    cmp("fill_pc", 32'(pc), 32'h00100);
    cmp("fill_nib", 32'(nibble), 32'h4);

    // Streaming: ack and pop every cycle.
    for (int i = 0; i < 16; i++) begin
      ack = 1'b1; data = 4'($urandom); inc = 1'b1; en = 1'b1;
      cyc();
    end

    // Reset mid-operation with a request pending and an ack during reset.
    idle_inputs(); rst_n = 1'b0; cyc();
    idle_inputs(); cyc();
    for (int i = 0; i < 3; i++) begin
      ack = 1'b1; data = 4'(i); cyc();
    end
    pre_level = (EFF < 3) ? 3'(EFF) : 3'd3;
    cmp("mid_level", 32'(level), 32'(pre_level));
    cmp("mid_req", 32'(bus_req), 32'(PF));
    rst_n = 1'b0; ack = 1'b1; cyc();
    cmp("rst_req", 32'(bus_req), 32'd0);
    cmp("rst_level", 32'(level), 32'd0);
    cmp("rst_stalled", 32'(stalled), 32'd1);
    cmp("rst_addr", 32'(bus_addr), 32'(RPC));
    cmp("rst_pc", 32'(pc), 32'd0);
    cmp("rst_nib", 32'(nibble), 32'd0);

    // Randomized traffic against the model.
    idle_inputs();
    for (int i = 0; i < 4000; i++) begin
      rst_n  = ($urandom % 300) != 0;
      load   = ($urandom % 40) == 0;
      new_pc = ($urandom % 2) ? (20'hFFFF0 | 20'($urandom % 16)) : 20'($urandom);
      ack    = ($urandom % 2) == 0;
      data   = 4'($urandom);
      inc    = ($urandom % 5) < 3;
      en     = ($urandom % 5) != 0;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
